// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flip-flop walk
// two WIDTH-bit operands LSB-first, framed by a start/busy/done handshake.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned    CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             bit_s, bit_c;

    always_comb begin
        bit_s   = a_q[0] ^ b_q[0] ^ carry_q;
        bit_c   = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    state_d = S_ADD;
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                end
            end
            S_ADD: begin
                // Result bits shift into A's vacated MSB side, so A ends up
                // holding the full result without a separate shift register.
                a_d     = {bit_s, a_q[WIDTH-1:1]};
                b_d     = {1'b0, b_q[WIDTH-1:1]};
                carry_d = bit_c;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    sum_d   = {bit_s, a_q[WIDTH-1:1]};
                    cout_d  = bit_c;
                    ovf_d   = carry_q ^ bit_c;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy = (state_q == S_ADD);
        done = (state_q == S_DONE);
        sum  = sum_q;
        cout = cout_q;
        ovf  = ovf_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: WIDTH=8 and WIDTH=13 instances share
// stimulus and are checked against an arithmetic a+/-b reference model.
module tb_serial_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        sub_in = 1'b0;
    logic        cin_in = 1'b0;
    logic [63:0] a_in = '0;
    logic [63:0] b_in = '0;

    logic        busy8, done8, cout8, ovf8;
    logic [7:0]  sum8;
    logic        busy13, done13, cout13, ovf13;
    logic [12:0] sum13;

    int n_cmp = 0;
    int n_err = 0;

    // results captured by run_op
    bit          seen8, seen13;
    logic [7:0]  got_sum8;
    logic        got_c8, got_o8;
    logic [12:0] got_sum13;
    logic        got_c13, got_o13;
    int          busy_n8, done_n8, busy_n13;

    logic [7:0] da [6] = '{8'h00, 8'hFF, 8'h7F, 8'h0F, 8'h05, 8'h80};
    logic [7:0] db [6] = '{8'h00, 8'h01, 8'h01, 8'hF0, 8'h07, 8'h01};
    logic       dsub [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic       dcin [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [7:0] es [6] = '{8'h00, 8'h00, 8'h80, 8'h00, 8'hFE, 8'h7F};
    logic       ec [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic       eo [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start), .sub(sub_in),
        .a(a_in[7:0]), .b(b_in[7:0]), .cin(cin_in),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    serial_adder #(.WIDTH(13)) dut13 (
        .clk(clk), .rst(rst), .start(start), .sub(sub_in),
        .a(a_in[12:0]), .b(b_in[12:0]), .cin(cin_in),
        .busy(busy13), .done(done13), .sum(sum13), .cout(cout13), .ovf(ovf13)
    );

    // Reference: unsigned result modulo 2^w, unsigned carry/no-borrow, and
    // signed overflow as "true signed result out of w-bit range".
    function automatic void model(input int w, input longint unsigned av, bv,
                                  input bit sv, cv, output longint unsigned s,
                                  output bit co, output bit ov);
        longint unsigned mask, full;
        longint          sa, sb, res, half;
        mask = (64'd1 << w) - 1;
        half = longint'(64'd1 << (w - 1));
        av   = av & mask;
        bv   = bv & mask;
        sa   = (av >= longint'(half)) ? longint'(av) - 2 * half : longint'(av);
        sb   = (bv >= longint'(half)) ? longint'(bv) - 2 * half : longint'(bv);
        if (sv) begin
            co  = (av >= bv);
            s   = (av - bv) & mask;
            res = sa - sb;
        end else begin
            full = av + bv + longint'(cv);
            co   = (full > mask);
            s    = full & mask;
            res  = sa + sb + longint'(cv);
        end
        ov = (res < -half) || (res > half - 1);
    endfunction

    // Caller sits on a negedge. Returns on the negedge where both DUTs have
    // shown done; inject_at >= 0 pulses a 11+22 start request mid-operation.
    task automatic run_op(input longint unsigned av, bv, input bit sv, cv,
                          input bit scramble, input int inject_at);
        a_in = av; b_in = bv; sub_in = sv; cin_in = cv; start = 1'b1;
        seen8 = 0; seen13 = 0; busy_n8 = 0; done_n8 = 0; busy_n13 = 0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (busy8) busy_n8++;
            if (busy13) busy_n13++;
            if (done8) begin
                done_n8++;
                if (!seen8) begin got_sum8 = sum8; got_c8 = cout8; got_o8 = ovf8; end
                seen8 = 1;
            end
            if (done13 && !seen13) begin
                got_sum13 = sum13; got_c13 = cout13; got_o13 = ovf13; seen13 = 1;
            end
            if (seen8 && seen13) break;
            if (i == inject_at) begin
                start = 1'b1; a_in = 64'h11; b_in = 64'h22;
            end else if (i == inject_at + 1) begin
                start = 1'b0;
            end
            if (scramble) begin
                a_in = {$urandom, $urandom}; b_in = {$urandom, $urandom};
                sub_in = 1'($urandom); cin_in = 1'($urandom);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (!(seen8 && seen13)) begin
            n_err++;
            $display("FAIL done_timeout: got seen8=%0b seen13=%0b want 1 1", seen8, seen13);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({busy8, done8, sum8, cout8, ovf8} !== 12'h000) begin
            n_err++;
            $display("FAIL reset8: got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
                     busy8, done8, sum8, cout8, ovf8);
        end
        n_cmp++;
        if ({busy13, done13, sum13, cout13, ovf13} !== 17'h0) begin
            n_err++;
            $display("FAIL reset13: got busy=%b done=%b sum=%h want all 0", busy13, done13, sum13);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        longint unsigned ms;
        bit mc, mo;
        for (int k = 0; k < 6; k++) begin
            run_op({56'h0, da[k]}, {56'h0, db[k]}, dsub[k], dcin[k], 1'b0, -1);
            n_cmp++;
            if ({got_sum8, got_c8, got_o8} !== {es[k], ec[k], eo[k]}) begin
                n_err++;
                $display("FAIL directed%0d: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                         k, got_sum8, got_c8, got_o8, es[k], ec[k], eo[k]);
            end
            n_cmp++;
            if (busy_n8 !== 8 || done_n8 !== 1) begin
                n_err++;
                $display("FAIL handshake%0d: got busy_cycles=%0d done_cycles=%0d want 8 1",
                         k, busy_n8, done_n8);
            end
            model(13, {56'h0, da[k]}, {56'h0, db[k]}, dsub[k], dcin[k], ms, mc, mo);
            n_cmp++;
            if ({got_sum13, got_c13, got_o13} !== {ms[12:0], mc, mo} || busy_n13 !== 13) begin
                n_err++;
                $display("FAIL directed13_%0d: got sum=%h cout=%b ovf=%b busy=%0d want sum=%h cout=%b ovf=%b busy=13",
                         k, got_sum13, got_c13, got_o13, busy_n13, ms[12:0], mc, mo);
            end
        end
    endtask

    task automatic test_start_while_busy();
        run_op(64'h01, 64'h01, 1'b0, 1'b0, 1'b0, 2);
        n_cmp++;
        if (got_sum8 !== 8'h02) begin
            n_err++;
            $display("FAIL busy_start_result: got %h want 02", got_sum8);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (sum8 !== 8'h02 || busy8 !== 1'b0 || done8 !== 1'b0) begin
            n_err++;
            $display("FAIL busy_start_dropped: got sum=%h busy=%b done=%b want 02 0 0",
                     sum8, busy8, done8);
        end
    endtask

    task automatic test_back_to_back();
        int  bn;
        bit  found;
        a_in = 64'h01; b_in = 64'h02; sub_in = 0; cin_in = 0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (done8) found = 1;
            else @(negedge clk);
        end
        n_cmp++;
        if (!found || sum8 !== 8'h03) begin
            n_err++;
            $display("FAIL b2b_first: got found=%b sum=%h want 1 03", found, sum8);
        end
        a_in = 64'h10; b_in = 64'h20; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (done8 !== 1'b0 || busy8 !== 1'b1 || sum8 !== 8'h03) begin
            n_err++;
            $display("FAIL b2b_restart: got done=%b busy=%b sum=%h want 0 1 03", done8, busy8, sum8);
        end
        bn = 0; found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (done8) found = 1;
            else begin
                if (busy8) bn++;
                if (sum8 !== 8'h03) begin
                    n_cmp++; n_err++;
                    $display("FAIL b2b_hold: got %h want 03", sum8);
                end
                @(negedge clk);
            end
        end
        n_cmp++;
        if (!found || sum8 !== 8'h30 || bn !== 8) begin
            n_err++;
            $display("FAIL b2b_second: got found=%b sum=%h busy_cycles=%0d want 1 30 8", found, sum8, bn);
        end
        for (int i = 0; i < 30 && (busy13 || done13); i++) @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        int dn;
        a_in = 64'h37; b_in = 64'h22; sub_in = 0; cin_in = 0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({busy8, done8, sum8, cout8, ovf8, busy13, sum13} !== 26'h0) begin
            n_err++;
            $display("FAIL reset_mid: got busy=%b done=%b sum=%h busy13=%b sum13=%h want all 0",
                     busy8, done8, sum8, busy13, sum13);
        end
        rst = 1'b0;
        dn = 0;
        repeat (30) begin
            @(negedge clk);
            if (done8 || done13) dn++;
        end
        n_cmp++;
        if (dn !== 0) begin
            n_err++;
            $display("FAIL reset_mid_no_done: got %0d done cycles want 0", dn);
        end
    endtask

    task automatic test_random();
        longint unsigned av, bv, ms;
        bit sv, cv, mc, mo;
        for (int k = 0; k < 200; k++) begin
            av = {$urandom, $urandom}; bv = {$urandom, $urandom};
            sv = 1'($urandom); cv = 1'($urandom);
            run_op(av, bv, sv, cv, 1'b1, -1);
            model(8, av, bv, sv, cv, ms, mc, mo);
            n_cmp++;
            if ({got_sum8, got_c8, got_o8} !== {ms[7:0], mc, mo}) begin
                n_err++;
                $display("FAIL random8_%0d: a=%h b=%h sub=%b cin=%b got %h/%b/%b want %h/%b/%b",
                         k, av[7:0], bv[7:0], sv, cv, got_sum8, got_c8, got_o8, ms[7:0], mc, mo);
            end
            model(13, av, bv, sv, cv, ms, mc, mo);
            n_cmp++;
            if ({got_sum13, got_c13, got_o13} !== {ms[12:0], mc, mo}) begin
                n_err++;
                $display("FAIL random13_%0d: a=%h b=%h sub=%b cin=%b got %h/%b/%b want %h/%b/%b",
                         k, av[12:0], bv[12:0], sv, cv, got_sum13, got_c13, got_o13, ms[12:0], mc, mo);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
